// File: rtl/spi_command_bridge.sv
// SPI mode-0 peripheral bridging host MOSI bytes into an RX FIFO (valid/ready out)
// and serialising command response bytes back on MISO. Everything runs on clk.
module spi_command_bridge #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       cmd_in_valid,
  input  logic       cmd_in_ready,
  output logic [7:0] cmd_in_data,
  input  logic       cmd_out_valid,
  output logic       cmd_out_ready,
  input  logic [7:0] cmd_out_data,
  input  logic       cmd_reset,
  output logic       rx_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  // cs_n chain resets low so a still-low chip select after reset shows no fall
  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_d, cs_d;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;
  assign mosi      = mosi_sync[1];

  state_t     state, state_nx;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift;
  logic       load_ev, rx_push;

  always_comb begin
    state_nx      = state;
    load_ev       = 1'b0;
    rx_push       = 1'b0;
    cmd_out_ready = 1'b0;
    case (state)
      IDLE:   if (cs_fall) state_nx = LOAD;
      LOAD: begin
        load_ev  = 1'b1;
        state_nx = cs_rise ? IDLE : ACTIVE;
      end
      ACTIVE: begin
        if (cs_rise) state_nx = IDLE;
        else begin
          load_ev = sclk_fall && (bit_cnt == 3'd0);
          rx_push = sclk_rise && (bit_cnt == 3'd7);
        end
      end
      default: state_nx = IDLE;
    endcase
    cmd_out_ready = load_ev && cmd_out_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      spi_miso <= 1'b0;
    end else begin
      state <= state_nx;
      if (state != ACTIVE || cs_rise) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= {rx_shift[6:0], mosi};
      end
      // Load takes the counter==0 fall; every other fall advances the bit
      if (load_ev)
        tx_shift <= cmd_out_valid ? cmd_out_data : IDLE_BYTE;
      else if (state == ACTIVE && sclk_fall)
        tx_shift <= {tx_shift[6:0], 1'b0};
      spi_miso <= (state == ACTIVE) ? tx_shift[7] : 1'b0;
    end
  end

  // RX FIFO, first-word fall-through
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, pop, push_ok;

  assign empty        = (count == '0);
  assign full         = (count == CW'(FIFO_DEPTH));
  assign cmd_in_valid = !empty;
  assign cmd_in_data  = mem[rd_ptr];
  assign pop          = cmd_in_valid && cmd_in_ready;
  assign push_ok      = rx_push && !cmd_reset && (!full || pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_overflow <= 1'b0;
    end else if (cmd_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (rx_push && full && !pop) rx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {rx_shift[6:0], mosi};
  end

endmodule

// File: tb/tb_spi_command_bridge.sv
// Bench for spi_command_bridge: bit-level SPI host, byte-queue RX model and
// response queue model; RX bytes are scoreboarded as they leave cmd_in.
module tb_spi_command_bridge;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso;
  logic       cmd_in_valid, cmd_in_ready = 1'b0;
  logic [7:0] cmd_in_data;
  logic       cmd_out_valid = 1'b0, cmd_out_ready;
  logic [7:0] cmd_out_data = 8'h00;
  logic       cmd_reset = 1'b0, rx_overflow;

  int total = 0, bad = 0;
  int hs_cnt = 0, out_pulses = 0;
  logic [7:0] mq[$];      // expected RX stream
  logic [7:0] resp_q[$];  // pending response bytes
  bit mov = 0;            // expected overflow flag

  spi_command_bridge #(.FIFO_DEPTH(DEPTH), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .rstn(rstn), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .cmd_in_valid(cmd_in_valid),
    .cmd_in_ready(cmd_in_ready), .cmd_in_data(cmd_in_data),
    .cmd_out_valid(cmd_out_valid), .cmd_out_ready(cmd_out_ready),
    .cmd_out_data(cmd_out_data), .cmd_reset(cmd_reset), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // RX scoreboard
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk); #1;
      if (rstn && !cmd_reset && cmd_in_valid && cmd_in_ready) begin
        hs_cnt++;
        total++;
        if (mq.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected got=%02h exp=none", cmd_in_data);
        end else begin
          e = mq.pop_front();
          if (cmd_in_data !== e) begin
            bad++;
            $display("FAIL rx_data got=%02h exp=%02h", cmd_in_data, e);
          end
        end
      end
    end
  end

  // Response source: offers resp_q head, retires it after a handshake
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = (cmd_out_ready === 1'b1);
      if (hs) out_pulses++;
      @(posedge clk); #1;
      if (hs && resp_q.size() > 0) void'(resp_q.pop_front());
      cmd_out_valid = (resp_q.size() > 0);
      cmd_out_data  = (resp_q.size() > 0) ? resp_q[0] : 8'h00;
    end
  end

  function automatic void model_push(input logic [7:0] b);
    if (mq.size() >= DEPTH) mov = 1;
    else mq.push_back(b);
  endfunction

  // n bits MSB first at sclk = clk/8; MISO sampled just before each rise
  task automatic spi_bits(input logic [7:0] tx, input int n, input bit push,
                          input bit rnd_ready, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      if (rnd_ready) cmd_in_ready = 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      if (push && n == 8 && i == 7) model_push(tx);
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_hi();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 4;
    if (cmd_in_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", cmd_in_valid); end
    if (cmd_out_ready !== 1'b0) begin bad++; $display("FAIL rst_out_ready got=%b exp=0", cmd_out_ready); end
    if (spi_miso !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b exp=0", spi_miso); end
    if (rx_overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", rx_overflow); end
    rstn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] rx;
    int h0 = hs_cnt;
    cmd_in_ready = 1'b1;
    cs_lo();
    spi_bits(8'hA5, 8, 1, 0, rx);
    cs_hi();
    total += 3;
    if (hs_cnt - h0 !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", hs_cnt - h0); end
    if (rx_overflow !== mov) begin bad++; $display("FAIL single_ovf got=%b exp=%b", rx_overflow, mov); end
    if (cmd_in_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", cmd_in_valid); end
  endtask

  task automatic test_response();
    logic [7:0] rx1, rx2;
    int p0;
    resp_q.push_back(8'h3C);
    repeat (3) @(negedge clk);
    p0 = out_pulses;
    cs_lo();
    spi_bits(8'hFF, 8, 1, 0, rx1);
    spi_bits(8'hFF, 8, 1, 0, rx2);
    cs_hi();
    total += 3;
    if (rx1 !== 8'h3C) begin bad++; $display("FAIL resp_byte got=%02h exp=3c", rx1); end
    if (rx2 !== 8'h00) begin bad++; $display("FAIL resp_idle got=%02h exp=00", rx2); end
    if (out_pulses - p0 !== 1) begin bad++; $display("FAIL resp_pulses got=%0d exp=1", out_pulses - p0); end
  endtask

  task automatic test_overflow();
    logic [7:0] rx;
    int h0;
    cmd_in_ready = 1'b0;
    cs_lo();
    for (int i = 1; i <= 17; i++) spi_bits(8'(i), 8, 1, 0, rx);
    cs_hi();
    total += 2;
    if (rx_overflow !== mov) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", rx_overflow, mov); end
    if (cmd_in_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", cmd_in_valid); end
    h0 = hs_cnt;
    cmd_in_ready = 1'b1;
    repeat (40) @(negedge clk);
    total += 2;
    if (hs_cnt - h0 !== DEPTH) begin bad++; $display("FAIL ovf_drain got=%0d exp=%0d", hs_cnt - h0, DEPTH); end
    if (cmd_in_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", cmd_in_valid); end
  endtask

  task automatic test_partial();
    logic [7:0] rx;
    int h0 = hs_cnt;
    cmd_in_ready = 1'b1;
    cs_lo();
    spi_bits(8'hF3, 5, 0, 0, rx);
    cs_hi();
    total += 1;
    if (hs_cnt - h0 !== 0) begin bad++; $display("FAIL partial_drop got=%0d exp=0", hs_cnt - h0); end
    cs_lo();
    spi_bits(8'h5A, 8, 1, 0, rx);
    cs_hi();
    total += 1;
    if (hs_cnt - h0 !== 1) begin bad++; $display("FAIL partial_next got=%0d exp=1", hs_cnt - h0); end
  endtask

  task automatic test_cmd_reset();
    logic [7:0] rx;
    int h0;
    cmd_in_ready = 1'b0;
    cs_lo();
    for (int i = 0; i < 4; i++) spi_bits(8'($urandom), 8, 1, 0, rx);
    cs_hi();
    total += 2;
    if (cmd_in_valid !== 1'b1) begin bad++; $display("FAIL creset_pre_valid got=%b exp=1", cmd_in_valid); end
    if (rx_overflow !== mov) begin bad++; $display("FAIL creset_pre_ovf got=%b exp=%b", rx_overflow, mov); end
    cmd_reset = 1'b1;
    mq.delete();
    mov = 0;
    @(negedge clk);
    cmd_reset = 1'b0;
    total += 2;
    if (cmd_in_valid !== 1'b0) begin bad++; $display("FAIL creset_valid got=%b exp=0", cmd_in_valid); end
    if (rx_overflow !== mov) begin bad++; $display("FAIL creset_ovf got=%b exp=%b", rx_overflow, mov); end
    h0 = hs_cnt;
    cmd_in_ready = 1'b1;
    cs_lo();
    spi_bits(8'h77, 8, 1, 0, rx);
    cs_hi();
    total += 1;
    if (hs_cnt - h0 !== 1) begin bad++; $display("FAIL creset_after got=%0d exp=1", hs_cnt - h0); end
  endtask

  task automatic test_rstn_mid();
    logic [7:0] rx;
    int h0 = hs_cnt;
    cmd_in_ready = 1'b1;
    cs_lo();
    spi_bits(8'($urandom), 4, 0, 0, rx);
    rstn = 1'b0;
    #1;
    total += 1;
    if (spi_miso !== 1'b0) begin bad++; $display("FAIL rstn_miso got=%b exp=0", spi_miso); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    mov = 0;
    spi_bits(8'($urandom), 8, 0, 0, rx);
    repeat (8) @(negedge clk);
    total += 2;
    if (hs_cnt - h0 !== 0) begin bad++; $display("FAIL rstn_nopush got=%0d exp=0", hs_cnt - h0); end
    if (cmd_in_valid !== 1'b0) begin bad++; $display("FAIL rstn_valid got=%b exp=0", cmd_in_valid); end
    cs_hi();
    cs_lo();
    spi_bits(8'hC3, 8, 1, 0, rx);
    cs_hi();
    total += 2;
    if (hs_cnt - h0 !== 1) begin bad++; $display("FAIL rstn_fresh got=%0d exp=1", hs_cnt - h0); end
    if (rx_overflow !== mov) begin bad++; $display("FAIL rstn_ovf got=%b exp=%b", rx_overflow, mov); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 10;
    logic [7:0] tx [N];
    logic [7:0] rsp [N];
    logic [7:0] rx;
    int h0 = hs_cnt, p0;
    for (int i = 0; i < N; i++) begin
      tx[i]  = 8'($urandom);
      rsp[i] = 8'($urandom);
      resp_q.push_back(rsp[i]);
    end
    repeat (3) @(negedge clk);
    p0 = out_pulses;
    cs_lo();
    for (int i = 0; i < N; i++) begin
      spi_bits(tx[i], 8, 1, 1, rx);
      total++;
      if (rx !== rsp[i]) begin bad++; $display("FAIL b2b_miso[%0d] got=%02h exp=%02h", i, rx, rsp[i]); end
    end
    cs_hi();
    cmd_in_ready = 1'b1;
    repeat (30) @(negedge clk);
    total += 3;
    if (out_pulses - p0 !== N) begin bad++; $display("FAIL b2b_pulses got=%0d exp=%0d", out_pulses - p0, N); end
    if (hs_cnt - h0 !== N) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", hs_cnt - h0, N); end
    if (cmd_in_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", cmd_in_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_response();
    test_overflow();
    test_partial();
    test_cmd_reset();
    test_rstn_mid();
    test_back_to_back();
    if (mq.size() != 0) begin
      bad++;
      $display("FAIL leftover_rx got=%0d exp=0", mq.size());
    end
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
